// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
// Holds the byte PC, drives the instruction-memory word index, and buffers the
// returned instructions in a small circular queue. The queue head goes to decode
// over a valid/ready handshake. A taken-branch redirect flushes the queue and
// reloads the PC. An ECALL parks the unit in HALTED until the next redirect.
// Optional build macro: FETCH_PERF_CNT_EN adds FetchCount/StallCount outputs.
module fetch_unit #(
  parameter logic [63:0] ResetVector = 64'h4,
  parameter int          QueueDepth  = 2      // 2 or 4
) (
  input  logic        Clock,
  input  logic        ResetN,
  output logic [63:0] Address,
  input  logic [31:0] Instruction,
  input  logic        RedirectValid,
  input  logic [63:0] RedirectTarget,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutInstruction,
  output logic [63:0] OutPC,
  output logic        Halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
`endif
);

  localparam int PW = $clog2(QueueDepth);
  localparam int CW = $clog2(QueueDepth + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(QueueDepth);
  localparam logic [31:0]   ECALL   = 32'h0000_0073;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [63:0]   pc, pc_nxt;
  logic          push, pop;

  logic [31:0]   q_instr [QueueDepth];
  logic [63:0]   q_pc    [QueueDepth];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  // Next-state, next-PC and push decision.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    pop       = OutValid && OutReady;
    if (RedirectValid) begin
      // Redirect overrides IDLE and a same-cycle ECALL; low two bits are dropped.
      state_nxt = RUN;
      pc_nxt    = RedirectTarget & ~64'h3;
    end else begin
      case (state)
        IDLE: state_nxt = RUN;
        RUN: begin
          // A full queue can still accept when the head leaves this cycle.
          if (count != DEPTH_C || pop) begin
            push   = 1'b1;
            pc_nxt = pc + 64'd4;
            if (Instruction == ECALL) state_nxt = HALTED;
          end
        end
        HALTED: state_nxt = HALTED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and PC registers.
  always_ff @(posedge Clock or negedge ResetN) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!ResetN) begin
      state <= IDLE;
      pc    <= ResetVector;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Queue storage: written at the write pointer on each push.
  always_ff @(posedge Clock or negedge ResetN) begin
    // NOTE: the storage is reset (it is only a few entries) because the head is
    // driven straight from it and must read as zero while in reset.
    if (!ResetN) begin
      for (int i = 0; i < QueueDepth; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (push) begin
      q_instr[wr_ptr] <= Instruction;
      q_pc[wr_ptr]    <= pc;
    end
  end

  // Queue pointers and occupancy; a redirect discards everything held.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (RedirectValid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // Depth is a power of two, so the natural pointer wrap is modulo depth.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating event counters; only reset clears them, never a flush.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      FetchCount <= '0;
      StallCount <= '0;
    end else begin
      if (push && FetchCount != '1) FetchCount <= FetchCount + 1'b1;
      if (state == RUN && !push && !RedirectValid && StallCount != '1)
        StallCount <= StallCount + 1'b1;
    end
  end
`endif

  assign Address        = {2'b00, pc[63:2]};
  assign OutValid       = (count != '0);
  assign OutInstruction = q_instr[rd_ptr];
  assign OutPC          = q_pc[rd_ptr];
  assign Halted         = (state == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit.
// A transaction-level reference model (a queue of expected {instruction, PC}
// entries plus a model PC and run/halt flag) is advanced on each rising edge.
// A monitor on the falling edge compares the DUT head against the scoreboard
// front and retires entries on each handshake.
module tb_fetch_unit;

  localparam logic [63:0] RV    = 64'h4;
  localparam int          DEPTH = 2;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic [63:0] Address;
  logic [31:0] Instruction;
  logic        RedirectValid;
  logic [63:0] RedirectTarget;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutInstruction;
  logic [63:0] OutPC;
  logic        Halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCount;
  logic [31:0] StallCount;
`endif

  fetch_unit #(.ResetVector(RV), .QueueDepth(DEPTH)) dut (
    .Clock          (Clock),
    .ResetN         (ResetN),
    .Address        (Address),
    .Instruction    (Instruction),
    .RedirectValid  (RedirectValid),
    .RedirectTarget (RedirectTarget),
    .OutValid       (OutValid),
    .OutReady       (OutReady),
    .OutInstruction (OutInstruction),
    .OutPC          (OutPC),
    .Halted         (Halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCount     (FetchCount),
    .StallCount     (StallCount)
`endif
  );

  always #5 Clock = ~Clock;

  // Instruction memory: a small programmed window, a non-ECALL pattern elsewhere.
  logic [31:0] mem [256];

  function automatic logic [31:0] imem(input logic [63:0] idx);
    if (idx < 64'd256) return mem[idx[7:0]];
    return {idx[23:0], 8'h13};
  endfunction

  assign Instruction = imem(Address);

  // Reference model state.
  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;
  typedef enum {M_IDLE, M_RUN, M_HALT} mstate_t;

  entry_t      exp_q [$];
  logic [63:0] m_pc;
  mstate_t     m_state;
  bit          mon_pop;
  int unsigned m_fetch, m_stall;
  int          occ;
  logic [31:0] m_word;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc    = RV;
    m_state = M_IDLE;
    mon_pop = 1'b0;
    m_fetch = 0;
    m_stall = 0;
  endtask

  // Model advance: what the fetch stage should do on this edge.
  always @(posedge Clock) begin
    if (ResetN) begin
      occ = exp_q.size() + (mon_pop ? 1 : 0);
      if (RedirectValid) begin
        exp_q.delete();
        m_pc    = {RedirectTarget[63:2], 2'b00};
        m_state = M_RUN;
      end else if (m_state == M_IDLE) begin
        m_state = M_RUN;
      end else if (m_state == M_RUN) begin
        if (occ < DEPTH || mon_pop) begin
          m_word = imem(m_pc >> 2);
          exp_q.push_back('{instr: m_word, pc: m_pc});
          m_fetch++;
          m_pc = m_pc + 64'd4;
          if (m_word == ECALL) m_state = M_HALT;
        end else begin
          m_stall++;
        end
      end
      mon_pop = 1'b0;
    end
  end

  // Monitor: compare DUT outputs with the model mid-cycle and retire accepted heads.
  always @(negedge Clock) begin
    if (ResetN) begin
      check("out_valid", {63'd0, OutValid}, {63'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        check("out_instr", {32'd0, OutInstruction}, {32'd0, exp_q[0].instr});
        check("out_pc", OutPC, exp_q[0].pc);
        if (OutReady) begin
          void'(exp_q.pop_front());
          mon_pop = 1'b1;
        end
      end
      check("address", Address, m_pc >> 2);
      check("halted", {63'd0, Halted}, {63'd0, m_state == M_HALT});
`ifdef FETCH_PERF_CNT_EN
      check("fetch_count", {32'd0, FetchCount}, {32'd0, m_fetch});
      check("stall_count", {32'd0, StallCount}, {32'd0, m_stall});
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},  {63'd0, OutValid}, 64'd0);
    check({tag, "_instr"},  {32'd0, OutInstruction}, 64'd0);
    check({tag, "_pc"},     OutPC, 64'd0);
    check({tag, "_halted"}, {63'd0, Halted}, 64'd0);
    check({tag, "_addr"},   Address, 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {i[23:0], 8'h13};
    mem[1] = 32'h015A04B3;
    mem[2] = 32'h40538333;
    mem[3] = 32'h00F6F1B3;
    mem[4] = 32'h00A5E733;
    mem[5] = ECALL;
    mem[7] = 32'h119C0267;

    ResetN         = 1'b0;
    RedirectValid  = 1'b0;
    RedirectTarget = '0;
    OutReady       = 1'b0;
    model_reset();
    step(2);
    check_reset_outputs("rst");

    // Stream words 1..5 with decode always ready; word 5 is ECALL.
    ResetN   = 1'b1;
    OutReady = 1'b1;
    step(8);
    check("halt_flag", {63'd0, Halted}, 64'd1);
    check("halt_addr", Address, 64'd6);
    step(2);
    check("halt_addr_frozen", Address, 64'd6);

    // Redirect to the reset vector, then hold decode off until the queue fills.
    RedirectValid  = 1'b1;
    RedirectTarget = 64'h4;
    step(1);
    RedirectValid = 1'b0;
    OutReady      = 1'b0;
    step(5);
    check("bp_addr", Address, 64'd3);
    check("bp_head_pc", OutPC, 64'd4);
    check("bp_head_instr", {32'd0, OutInstruction}, 64'h015A04B3);

    // Release, drain into the ECALL, then back-pressure with a full queue.
    OutReady = 1'b1;
    step(3);
    OutReady = 1'b0;
    step(4);
    RedirectValid  = 1'b1;
    RedirectTarget = 64'h1E;
    step(1);
    RedirectValid = 1'b0;
    check("redir_addr", Address, 64'd7);
    check("redir_flush", {63'd0, OutValid}, 64'd0);
    step(1);
    check("redir_instr", {32'd0, OutInstruction}, 64'h119C0267);
    check("redir_pc", OutPC, 64'h1C);

    // Randomized back-pressure and redirects, including PC wrap targets.
    for (int c = 0; c < 400; c++) begin
      OutReady      = ($urandom_range(0, 3) != 0);
      RedirectValid = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 4))
        0:       RedirectTarget = 64'h4;
        1:       RedirectTarget = 64'h10 | 64'($urandom_range(0, 3));
        2:       RedirectTarget = {$urandom, $urandom};
        3:       RedirectTarget = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 3));
        default: RedirectTarget = 64'h1E;
      endcase
      step(1);
    end

    // Steady streaming, then reset mid-cycle while push and pop coincide.
    OutReady       = 1'b1;
    RedirectValid  = 1'b1;
    RedirectTarget = 64'h100;
    step(1);
    RedirectValid = 1'b0;
    step(4);
    #2;
    ResetN = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("async_rst");
    step(1);
    ResetN = 1'b1;
    step(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
